// File: rtl/mini_src_pkg.sv
// Shared constants for the Mini SRC control path: opcodes, ALU codes,
// instruction classes and the sequencer state encodings.
package mini_src_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_OP_ADD = 5'b00011;
  localparam logic [4:0] ALU_OP_AND = 5'b01001;
  localparam logic [4:0] ALU_OP_OR  = 5'b01010;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_R    = 3'd1,
    CLS_I    = 3'd2,
    CLS_LDI  = 3'd3,
    CLS_LD   = 3'd4,
    CLS_ST   = 3'd5,
    CLS_HALT = 3'd6
  } op_class_t;

  localparam logic [4:0] ST_RST  = 5'd0;
  localparam logic [4:0] ST_T0   = 5'd1;
  localparam logic [4:0] ST_T1   = 5'd2;
  localparam logic [4:0] ST_T2   = 5'd3;
  localparam logic [4:0] ST_R3   = 5'd4;
  localparam logic [4:0] ST_R4   = 5'd5;
  localparam logic [4:0] ST_R5   = 5'd6;
  localparam logic [4:0] ST_I3   = 5'd7;
  localparam logic [4:0] ST_I4   = 5'd8;
  localparam logic [4:0] ST_I5   = 5'd9;
  localparam logic [4:0] ST_A3   = 5'd10;
  localparam logic [4:0] ST_A4   = 5'd11;
  localparam logic [4:0] ST_A5   = 5'd12;
  localparam logic [4:0] ST_L5   = 5'd13;
  localparam logic [4:0] ST_L6   = 5'd14;
  localparam logic [4:0] ST_L7   = 5'd15;
  localparam logic [4:0] ST_S5   = 5'd16;
  localparam logic [4:0] ST_S6   = 5'd17;
  localparam logic [4:0] ST_S7   = 5'd18;
  localparam logic [4:0] ST_HALT = 5'd19;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps the IR opcode field onto the execute-sequence family it selects.
module opcode_class_decode
  import mini_src_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR: op_class = CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI:                      op_class = CLS_I;
      OP_LDI:                                        op_class = CLS_LDI;
      OP_LD:                                         op_class = CLS_LD;
      OP_ST:                                         op_class = CLS_ST;
      OP_HALT:                                       op_class = CLS_HALT;
      default:                                       op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM for the Mini SRC datapath: fetch, execute and memory
// handshake sequencing, with all strobes decoded from the current state.
module control_sequencer
  import mini_src_pkg::*;
#(
  parameter int               OPCODE_W = 5,
  parameter int               STATE_W  = 5,
  parameter logic [OPCODE_W-1:0] ALU_ADD = 5'b00011
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_done,
  input  logic                stop,
  output logic                gra,
  output logic                grb,
  output logic                grc,
  output logic                rin,
  output logic                rout,
  output logic                baout,
  output logic                cout,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                read,
  output logic                write,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                zlow_out,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                run,
  output logic [STATE_W-1:0]  state_dbg
);

  logic [STATE_W-1:0]  state_q;
  logic [STATE_W-1:0]  state_d;
  logic [STATE_W-1:0]  done_next;
  logic [OPCODE_W-1:0] opcode;
  op_class_t           op_class;
  logic                unused_ir_bits;

  assign opcode         = ir[31 -: OPCODE_W];
  assign unused_ir_bits = ^ir[31-OPCODE_W:0];

  opcode_class_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // stop is only consulted on the edge that retires an instruction
  assign done_next = stop ? ST_HALT : ST_T0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  if (mem_done) state_d = ST_T2;
      ST_T2: begin
        case (op_class)
          CLS_R:                   state_d = ST_R3;
          CLS_I:                   state_d = ST_I3;
          CLS_LDI, CLS_LD, CLS_ST: state_d = ST_A3;
          CLS_HALT:                state_d = ST_HALT;
          default:                 state_d = ST_T0;
        endcase
      end
      ST_R3:  state_d = ST_R4;
      ST_R4:  state_d = ST_R5;
      ST_R5:  state_d = done_next;
      ST_I3:  state_d = ST_I4;
      ST_I4:  state_d = ST_I5;
      ST_I5:  state_d = done_next;
      ST_A3:  state_d = ST_A4;
      ST_A4: begin
        case (op_class)
          CLS_LD:  state_d = ST_L5;
          CLS_ST:  state_d = ST_S5;
          default: state_d = ST_A5;
        endcase
      end
      ST_A5:  state_d = done_next;
      ST_L5:  state_d = ST_L6;
      ST_L6:  if (mem_done) state_d = ST_L7;
      ST_L7:  state_d = done_next;
      ST_S5:  state_d = ST_S6;
      ST_S6:  state_d = ST_S7;
      ST_S7:  if (mem_done) state_d = done_next;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) state_q <= ST_RST;
    else       state_q <= state_d;
  end

  always_comb begin
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    rin      = 1'b0;
    rout     = 1'b0;
    baout    = 1'b0;
    cout     = 1'b0;
    pc_out   = 1'b0;
    pc_in    = 1'b0;
    inc_pc   = 1'b0;
    mar_in   = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    alu_op   = '0;
    run      = (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      ST_T1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      ST_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      ST_R3, ST_I3: begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
      ST_R4: begin grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = opcode; end
      ST_I4: begin
        cout = 1'b1;
        z_in = 1'b1;
        case (opcode)
          OP_ANDI: alu_op = ALU_OP_AND;
          OP_ORI:  alu_op = ALU_OP_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_R5, ST_I5, ST_A5: begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; end
      ST_A3: begin grb = 1'b1; baout = 1'b1; y_in = 1'b1; end
      ST_A4: begin cout = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      ST_L5, ST_S5: begin zlow_out = 1'b1; mar_in = 1'b1; end
      ST_L6: begin read = 1'b1; mdr_in = 1'b1; end
      ST_L7: begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
      ST_S6: begin gra = 1'b1; rout = 1'b1; mdr_in = 1'b1; end
      ST_S7: write = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: every cycle's expected state and
// strobes are queued with the inputs to apply, then popped and compared.
module tb_control_sequencer;
  import mini_src_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir = '0;
  logic        mem_done = 1'b0;
  logic        stop = 1'b0;
  logic gra, grb, grc, rin, rout, baout, cout, pc_out, pc_in, inc_pc;
  logic mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in, zlow_out;
  logic [4:0] alu_op;
  logic       run;
  logic [4:0] state_dbg;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_done(mem_done), .stop(stop),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .cout(cout), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc),
    .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .read(read),
    .write(write), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .zlow_out(zlow_out), .alu_op(alu_op), .run(run), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic gra, grb, grc, rin, rout, baout, cout, pc_out, pc_in, inc_pc;
    logic mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in, zlow_out;
  } strb_t;

  typedef struct {
    logic [4:0]  st;
    logic [4:0]  alu;
    logic        run;
    logic        md;
    logic        stp;
    logic        clr;
    logic [31:0] ir;
  } ent_t;

  ent_t        q[$];
  logic [31:0] cur_ir = '0;
  int          n_tests = 0;
  int          n_fail  = 0;
  strb_t       obs;

  assign obs = {gra, grb, grc, rin, rout, baout, cout, pc_out, pc_in, inc_pc,
                mar_in, mdr_in, mdr_out, read, write, ir_in, y_in, z_in, zlow_out};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic strb_t exp_strb(input logic [4:0] s);
    strb_t e;
    e = '0;
    case (s)
      ST_T0: begin e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; end
      ST_T1: begin e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1; end
      ST_T2: begin e.mdr_out = 1; e.ir_in = 1; end
      ST_R3: begin e.grb = 1; e.rout = 1; e.y_in = 1; end
      ST_R4: begin e.grc = 1; e.rout = 1; e.z_in = 1; end
      ST_R5: begin e.zlow_out = 1; e.gra = 1; e.rin = 1; end
      ST_I3: begin e.grb = 1; e.rout = 1; e.y_in = 1; end
      ST_I4: begin e.cout = 1; e.z_in = 1; end
      ST_I5: begin e.zlow_out = 1; e.gra = 1; e.rin = 1; end
      ST_A3: begin e.grb = 1; e.baout = 1; e.y_in = 1; end
      ST_A4: begin e.cout = 1; e.z_in = 1; end
      ST_A5: begin e.zlow_out = 1; e.gra = 1; e.rin = 1; end
      ST_L5: begin e.zlow_out = 1; e.mar_in = 1; end
      ST_L6: begin e.read = 1; e.mdr_in = 1; end
      ST_L7: begin e.mdr_out = 1; e.gra = 1; e.rin = 1; end
      ST_S5: begin e.zlow_out = 1; e.mar_in = 1; end
      ST_S6: begin e.gra = 1; e.rout = 1; e.mdr_in = 1; end
      ST_S7: begin e.write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input logic [4:0] st, input logic [4:0] alu,
                      input logic md = 1'b0, input logic stp = 1'b0, input logic clr = 1'b0);
    ent_t e;
    e.st = st; e.alu = alu; e.run = (st != ST_HALT);
    e.md = md; e.stp = stp; e.clr = clr; e.ir = cur_ir;
    q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] instr, input int w);
    cur_ir = instr;
    push(ST_T0, 5'b00011);
    for (int i = 0; i < w; i++) push(ST_T1, 5'b0);
    push(ST_T1, 5'b0, 1'b1);
    push(ST_T2, 5'b0);
  endtask

  task automatic r_type(input logic [4:0] alu, input logic stp);
    push(ST_R3, 5'b0, 1'b1);
    push(ST_R4, alu, 1'b0, stp);
    push(ST_R5, 5'b0, 1'b0, stp);
  endtask

  task automatic i_type(input logic [4:0] alu);
    push(ST_I3, 5'b0);
    push(ST_I4, alu);
    push(ST_I5, 5'b0);
  endtask

  task automatic addr_calc();
    push(ST_A3, 5'b0, 1'b1);
    push(ST_A4, 5'b00011);
  endtask

  initial begin
    // clear held for two edges, then released
    push(ST_RST, 5'b0, 1'b0, 1'b0, 1'b1);
    push(ST_RST, 5'b0);
    fetch(32'h18918000, 1); r_type(5'b00011, 1'b0);
    fetch(32'h00900055, 0); addr_calc(); push(ST_L5, 5'b0);
    for (int i = 0; i < 3; i++) push(ST_L6, 5'b0);
    push(ST_L6, 5'b0, 1'b1); push(ST_L7, 5'b0);
    fetch(32'h10900055, 2); addr_calc(); push(ST_S5, 5'b0); push(ST_S6, 5'b0);
    for (int i = 0; i < 2; i++) push(ST_S7, 5'b0);
    push(ST_S7, 5'b0, 1'b1);
    fetch(32'h08100010, 0); addr_calc(); push(ST_A5, 5'b0);
    fetch(32'h20000000, 0); r_type(5'b00100, 1'b0);
    fetch(32'h48000000, 0); r_type(5'b01001, 1'b0);
    fetch(32'h60000000, 0); i_type(5'b01001);
    fetch(32'h68000000, 0); i_type(5'b01010);
    fetch(32'h38000000, 0);
    fetch(32'h591FFFFF, 0); i_type(5'b00011);
    fetch(32'hD0000000, 0);
    for (int i = 0; i < 19; i++) push(ST_HALT, 5'b0, i[0], 1'b1);
    push(ST_HALT, 5'b0, 1'b0, 1'b0, 1'b1);
    push(ST_RST, 5'b0);
    fetch(32'h18918000, 0); r_type(5'b00011, 1'b1);
    push(ST_HALT, 5'b0, 1'b0, 1'b0, 1'b1);
    push(ST_RST, 5'b0);
    fetch(32'h00900055, 0); addr_calc(); push(ST_L5, 5'b0);
    push(ST_L6, 5'b0);
    push(ST_L6, 5'b0, 1'b0, 1'b0, 1'b1);
    push(ST_RST, 5'b0);
    push(ST_T0, 5'b00011);

    while (q.size() > 0) begin
      ent_t e;
      e = q.pop_front();
      @(posedge clock);
      #1;
      ir       = e.ir;
      mem_done = e.md;
      stop     = e.stp;
      clear    = e.clr;
      @(negedge clock);
      check($sformatf("state@%0t", $time), {27'b0, state_dbg}, {27'b0, e.st});
      check($sformatf("strobes@%0t st=%0d", $time, e.st), {13'b0, obs}, {13'b0, exp_strb(e.st)});
      check($sformatf("alu_op@%0t st=%0d", $time, e.st), {27'b0, alu_op}, {27'b0, e.alu});
      check($sformatf("run@%0t st=%0d", $time, e.st), {31'b0, run}, {31'b0, e.run});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
